// File: rtl/instr_mem_loader.sv
// Streams program bytes into 32-bit big-endian words and writes them to instruction memory.
// Holds the CPU for the whole load; one write per 4 accepted bytes.
module instr_mem_loader #(
  parameter int          MEM_WORDS = 128,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  word_count,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        mem_write_en,
  output logic [31:0] mem_write_address,
  output logic [31:0] mem_write_data,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done
);

  // word_count is 8 bits wide, so a depth beyond 255 never needs clamping.
  localparam logic [7:0] MAX_COUNT = (MEM_WORDS > 255) ? 8'd255 : 8'(MEM_WORDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  words_left;
  logic [31:0] addr;
  logic [1:0]  byte_idx;
  logic [23:0] partial;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [7:0]  clamped_count;
  logic        accept;

  always_comb begin
    clamped_count = word_count;
    if (word_count > MAX_COUNT) begin
      clamped_count = MAX_COUNT;
    end
  end

  assign accept = (state == RECV) && byte_valid;

  always_comb begin
    state_next   = state;
    byte_ready   = 1'b0;
    mem_write_en = 1'b0;
    cpu_hold     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (clamped_count == 8'd0) ? DONE : RECV;
        end
      end
      RECV: begin
        byte_ready = 1'b1;
        cpu_hold   = 1'b1;
        busy       = 1'b1;
        if (accept && (byte_idx == 2'd3)) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        mem_write_en = 1'b1;
        cpu_hold     = 1'b1;
        busy         = 1'b1;
        state_next   = (words_left == 8'd1) ? DONE : RECV;
      end
      DONE: begin
        done       = 1'b1;
        cpu_hold   = 1'b1;
        busy       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The write port registers are loaded together with the 4th byte so they are
  // valid throughout WRITE and then hold until the next word completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      words_left <= 8'd0;
      addr       <= BASE_ADDR;
      byte_idx   <= 2'd0;
      partial    <= 24'd0;
      wr_addr    <= BASE_ADDR;
      wr_data    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            words_left <= clamped_count;
            addr       <= BASE_ADDR;
            byte_idx   <= 2'd0;
          end
        end
        RECV: begin
          if (accept) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: partial[23:16] <= byte_in;
              2'd1: partial[15:8]  <= byte_in;
              2'd2: partial[7:0]   <= byte_in;
              default: begin
                wr_addr <= addr;
                wr_data <= {partial, byte_in};
              end
            endcase
          end
        end
        WRITE: begin
          addr       <= addr + 32'd4;
          words_left <= words_left - 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign mem_write_address = wr_addr;
  assign mem_write_data    = wr_data;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed + randomized checks of instr_mem_loader against a word-list reference model.
module tb_instr_mem_loader;
  localparam int          MEM_WORDS = 128;
  localparam logic [31:0] BASE      = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  word_count;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_write_en;
  logic [31:0] mem_write_address;
  logic [31:0] mem_write_data;
  logic        cpu_hold;
  logic        busy;
  logic        done;

  instr_mem_loader #(.MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .mem_write_en(mem_write_en), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .cpu_hold(cpu_hold), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  int          errors = 0;
  int          checks = 0;
  wr_t         wq[$];
  logic [7:0]  stream[$];
  logic        prev_we = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write monitor: logs every strobe and flags back-to-back strobes.
  always @(negedge clk) begin
    if (reset) begin
      prev_we = 1'b0;
    end else begin
      if (mem_write_en) begin
        wq.push_back('{a: mem_write_address, d: mem_write_data});
        chk("we_consecutive", {31'd0, prev_we}, 32'd0);
        chk("ready_in_write", {31'd0, byte_ready}, 32'd0);
      end
      prev_we = mem_write_en;
    end
  end

  task automatic gen_stream(input int nwords, input bit rnd);
    stream.delete();
    for (int i = 0; i < 4 * nwords; i++) begin
      stream.push_back(rnd ? 8'($urandom) : 8'(i));
    end
  endtask

  // Reference: word i lands at BASE+4i, bytes 4i..4i+3 big-endian, count clamped.
  task automatic compare_writes(input string tag, input int n);
    int m;
    m = (n > MEM_WORDS) ? MEM_WORDS : n;
    chk({tag, "_nwrites"}, wq.size(), m);
    for (int i = 0; i < m && i < wq.size(); i++) begin
      chk({tag, "_addr"}, wq[i].a, BASE + 32'(4 * i));
      chk({tag, "_data"}, wq[i].d,
          {stream[4*i], stream[4*i+1], stream[4*i+2], stream[4*i+3]});
    end
  endtask

  // mode: 100 = back-to-back, 0..99 = random valid %, -1 = toggle 1/0 each cycle.
  task automatic do_load(input int n, input int mode, input bit poke_start,
                         output int done_cyc, output int hold_first, output int hold_last);
    int   ptr;
    int   cyc;
    logic acc;
    ptr = 0;
    done_cyc = -1;
    hold_first = -1;
    hold_last = -1;
    wq.delete();
    start = 1'b1;
    word_count = 8'(n);
    byte_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 3000 && done_cyc < 0) begin
      if (poke_start) begin
        start = (cyc == 2);
        word_count = (cyc == 2) ? 8'd5 : 8'(n);
      end
      if (ptr >= stream.size()) byte_valid = 1'b0;
      else if (mode < 0) byte_valid = cyc[0];
      else byte_valid = ($urandom_range(99) < mode);
      byte_in = byte_valid ? stream[ptr] : 8'($urandom);
      @(negedge clk);
      if (cpu_hold) begin
        if (hold_first < 0) hold_first = cyc;
        hold_last = cyc;
      end
      if (done) done_cyc = cyc;
      acc = byte_valid && byte_ready;
      @(posedge clk); #1;
      if (acc) ptr++;
      cyc++;
    end
    start = 1'b0;
    byte_valid = 1'b0;
    chk("done_seen", {31'd0, done_cyc >= 0}, 32'd1);
    @(negedge clk);
    chk("idle_after_done_hold", {31'd0, cpu_hold}, 32'd0);
    chk("idle_after_done_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, {31'd0, byte_ready}, 32'd0);
    chk({tag, "_we"},    {31'd0, mem_write_en}, 32'd0);
    chk({tag, "_hold"},  {31'd0, cpu_hold}, 32'd0);
    chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
    chk({tag, "_done"},  {31'd0, done}, 32'd0);
    chk({tag, "_addr"},  mem_write_address, BASE);
    chk({tag, "_data"},  mem_write_data, 32'd0);
  endtask

  initial begin
    int dc, hf, hl, n;
    reset = 1'b1; start = 1'b0; word_count = 8'd0; byte_in = 8'd0; byte_valid = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // Basic two-word load, back-to-back bytes.
    stream.delete();
    stream = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
    do_load(2, 100, 1'b0, dc, hf, hl);
    compare_writes("basic", 2);
    chk("basic_done_cycle", dc, 11);
    chk("basic_hold_first", hf, 1);
    chk("basic_hold_last", hl, 11);

    // Toggled byte_valid stalls without losing bytes.
    stream = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    do_load(1, -1, 1'b0, dc, hf, hl);
    compare_writes("stall", 1);

    // Zero count goes straight to DONE.
    stream.delete();
    do_load(0, 100, 1'b0, dc, hf, hl);
    chk("zero_done_cycle", dc, 1);
    chk("zero_nwrites", wq.size(), 0);

    // Count above depth is clamped.
    gen_stream(MEM_WORDS, 1'b1);
    do_load(200, 100, 1'b0, dc, hf, hl);
    compare_writes("clamp", 200);
    chk("clamp_done_cycle", dc, 1 + 5 * MEM_WORDS);
    if (wq.size() > 0) chk("clamp_last_addr", wq[wq.size()-1].a, BASE + 32'h1FC);

    // Reset after two bytes of a word.
    wq.delete();
    start = 1'b1; word_count = 8'd1;
    @(posedge clk); #1; start = 1'b0;
    byte_valid = 1'b1; byte_in = 8'h12;
    @(posedge clk); #1; byte_in = 8'h34;
    @(posedge clk); #2; byte_valid = 1'b0;
    reset = 1'b1; #1;
    check_reset_outputs("midreset");
    @(negedge clk); reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midreset_nwrites", wq.size(), 0);
    chk("midreset_idle", {31'd0, busy}, 32'd0);
    stream = '{8'h00, 8'h00, 8'h00, 8'h01};
    do_load(1, 100, 1'b0, dc, hf, hl);
    compare_writes("after_reset", 1);

    // byte_valid held in IDLE is ignored; start pulsed in RECV is ignored.
    byte_valid = 1'b1; byte_in = 8'hAA;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_ready", {31'd0, byte_ready}, 32'd0);
      chk("idle_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    chk("idle_nwrites", wq.size(), 1);
    gen_stream(2, 1'b1);
    do_load(2, 70, 1'b1, dc, hf, hl);
    compare_writes("ignored", 2);

    // Randomized loads.
    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 9);
      gen_stream(n, 1'b1);
      do_load(n, $urandom_range(30, 100), 1'b0, dc, hf, hl);
      compare_writes("random", n);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
